// File: rtl/packet_assembler_pkg.sv
// Shared constants and types for the packet assembler and the instruction-memory writer.
package packet_assembler_pkg;

    localparam int unsigned PA_PKT_W  = 8;
    localparam int unsigned PA_NPKT   = 4;
    localparam int unsigned PA_WORD_W = PA_NPKT * PA_PKT_W;
    localparam logic [PA_WORD_W-1:0] PA_END_WORD = 32'hFFFF_FFFF;

    typedef logic [PA_WORD_W-1:0] instr_word_t;

    // Width needed to count 0..n packets inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe followed by a rising-edge pulse.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse_c
);

    logic [STAGES-1:0] sync_q;
    logic              edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= STAGES'({sync_q, async_in});
            edge_q <= sync_q[STAGES-1];
        end
    end

    assign pulse_c = sync_q[STAGES-1] & ~edge_q;

endmodule

// File: rtl/packet_assembler.sv
// Assembles NPKT byte packets (first packet in the MSBs) into one instruction word for the loader FSM.
module packet_assembler
    import packet_assembler_pkg::*;
#(
    parameter int unsigned PKT_W       = PA_PKT_W,
    parameter int unsigned NPKT        = PA_NPKT,
    parameter logic [NPKT*PKT_W-1:0] END_WORD = PA_END_WORD,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned WORD_W     = NPKT * PKT_W,
    localparam int unsigned CNT_W      = cnt_w(NPKT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PKT_W-1:0]  data_in,
    input  logic              strobe_in,
    input  logic              activreg,
    input  logic              rstcont,
    output logic [WORD_W-1:0] instr,
    output logic              listo,
    output logic              opcode,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              overrun
);

    logic              acc_c;
    logic              accept_c;
    logic              last_c;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_next_c;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst),
        .async_in (strobe_in),
        .pulse_c  (acc_c)
    );

    // Packets are taken only while the FSM is collecting and no finished word is pending.
    assign accept_c     = acc_c & activreg & ~rstcont & ~listo & ~opcode;
    assign last_c       = (pkt_cnt == CNT_W'(NPKT - 1));
    assign shift_next_c = WORD_W'({shift_q, data_in});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            instr   <= '0;
            pkt_cnt <= '0;
            listo   <= 1'b0;
            opcode  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (acc_c && !accept_c) begin
                overrun <= 1'b1;
            end
            if (rstcont) begin
                pkt_cnt <= '0;
                listo   <= 1'b0;
            end else if (accept_c) begin
                shift_q <= shift_next_c;
                pkt_cnt <= pkt_cnt + CNT_W'(1);
                // Completing packet publishes the word on the same edge.
                if (last_c) begin
                    instr  <= shift_next_c;
                    listo  <= 1'b1;
                    opcode <= (shift_next_c == END_WORD);
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_assembler.sv
// Randomized and directed bench for packet_assembler against a byte-queue reference model.
module tb_packet_assembler;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        strobe_in;
    logic        activreg;
    logic        rstcont;
    logic [31:0] instr;
    logic        listo;
    logic        opcode;
    logic [2:0]  pkt_cnt;
    logic        overrun;

    int unsigned n_checks;
    int unsigned n_pass;

    // Reference model state.
    logic [7:0]  m_q[$];
    logic [31:0] m_instr;
    logic        m_listo;
    logic        m_opcode;
    logic        m_overrun;

    packet_assembler dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .strobe_in (strobe_in),
        .activreg  (activreg),
        .rstcont   (rstcont),
        .instr     (instr),
        .listo     (listo),
        .opcode    (opcode),
        .pkt_cnt   (pkt_cnt),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_cnt"},     32'(pkt_cnt), 32'(m_q.size()));
        check({tag, "_instr"},   instr,        m_instr);
        check({tag, "_listo"},   32'(listo),   32'(m_listo));
        check({tag, "_opcode"},  32'(opcode),  32'(m_opcode));
        check({tag, "_overrun"}, 32'(overrun), 32'(m_overrun));
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_instr   = '0;
        m_listo   = 1'b0;
        m_opcode  = 1'b0;
        m_overrun = 1'b0;
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_listo = 1'b0;
    endfunction

    // One strobe arriving; clr says the FSM clear coincides with it.
    function automatic void model_packet(input logic [7:0] b, input bit act, input bit clr);
        if (clr) begin
            model_clear();
            m_overrun = 1'b1;
        end else if (act && !m_listo && !m_opcode) begin
            m_q.push_back(b);
            if (m_q.size() == 4) begin
                m_instr  = {m_q[0], m_q[1], m_q[2], m_q[3]};
                m_listo  = 1'b1;
                m_opcode = (m_instr == 32'hFFFF_FFFF);
                m_q.delete();
            end
        end else begin
            m_overrun = 1'b1;
        end
    endfunction

    // Model count after a completed word reads back as NPKT until cleared.
    function automatic int unsigned model_cnt();
        return m_listo ? 4 : m_q.size();
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_cnt"},     32'(pkt_cnt), 32'(model_cnt()));
        check({tag, "_instr"},   instr,        m_instr);
        check({tag, "_listo"},   32'(listo),   32'(m_listo));
        check({tag, "_opcode"},  32'(opcode),  32'(m_opcode));
        check({tag, "_overrun"}, 32'(overrun), 32'(m_overrun));
    endtask

    task automatic send(input logic [7:0] b, input bit clr_at_acc);
        int unsigned pre_cnt;
        data_in = b;
        @(posedge clk); #1;
        strobe_in = 1'b1;
        pre_cnt = model_cnt();
        @(posedge clk); @(posedge clk); #1;
        check("pre_acc_cnt", 32'(pkt_cnt), 32'(pre_cnt));
        if (clr_at_acc) rstcont = 1'b1;
        @(posedge clk); #1;
        rstcont = 1'b0;
        model_packet(b, activreg, clr_at_acc);
        check_model("post_acc");
        repeat (2) @(posedge clk);
        #1 strobe_in = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic pulse_rstcont();
        logic save_act;
        save_act = activreg;
        @(posedge clk); #1;
        activreg = 1'b0;
        rstcont  = 1'b1;
        @(posedge clk); #1;
        rstcont  = 1'b0;
        activreg = save_act;
        model_clear();
        check_model("rstcont");
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_model("rst_release");
    endtask

    initial begin
        logic [7:0] b;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        data_in   = '0;
        strobe_in = 1'b0;
        activreg  = 1'b0;
        rstcont   = 1'b0;
        model_reset();

        #7;
        check_model("in_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_model("idle");
        end

        // First word, big-endian assembly.
        activreg = 1'b1;
        send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
        check("word1", instr, 32'h1234_5678);
        check("word1_listo", 32'(listo), 32'd1);
        pulse_rstcont();
        check("word1_held", instr, 32'h1234_5678);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
        check("word2", instr, 32'hAABB_CCDD);
        pulse_rstcont();

        // End-of-program word, then a packet that must be dropped.
        for (int i = 0; i < 4; i++) send(8'hFF, 0);
        check("end_opcode", 32'(opcode), 32'd1);
        pulse_rstcont();
        send(8'h11, 0);
        check("end_drop_overrun", 32'(overrun), 32'd1);
        check("end_instr_kept", instr, 32'hFFFF_FFFF);
        pulse_rstcont();
        check("opcode_sticky", 32'(opcode), 32'd1);

        // Drops while disabled and while a word is pending.
        do_reset();
        activreg = 1'b0;
        send(8'h55, 0);
        check("inactive_cnt", 32'(pkt_cnt), 32'd0);
        activreg = 1'b1;
        send(8'h01, 0); send(8'h23, 0); send(8'h45, 0); send(8'h67, 0);
        send(8'h89, 0);
        check("listo_drop_cnt", 32'(pkt_cnt), 32'd4);
        check("listo_drop_instr", instr, 32'h0123_4567);

        // Clear colliding with a packet.
        do_reset();
        activreg = 1'b1;
        send(8'h9A, 0);
        send(8'hBC, 1);
        check("collide_overrun", 32'(overrun), 32'd1);

        // Reset in the middle of a word.
        do_reset();
        activreg = 1'b1;
        send(8'hDE, 0); send(8'hAD, 0);
        do_reset();
        check("midword_instr", instr, 32'd0);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        check("word_after_rst", instr, 32'h0102_0304);
        pulse_rstcont();

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            int unsigned r;
            r = $urandom_range(0, 19);
            if (r == 0) do_reset();
            else if (r < 3 || (m_listo && r < 12)) pulse_rstcont();
            activreg = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            send(b, ($urandom_range(0, 24) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/packet_assembler.md
Name: packet_assembler

Overview:
- Upstream feeder of the input-loading control FSM.
- Receives byte-wide packets from the serial receiver and assembles NPKT packets into one instruction word.
- Raises `listo` when a word is complete and `opcode` when the end-of-program word arrives.
- Obeys the FSM's `activreg` (capture enable) and `rstcont` (counter clear) controls, and holds `instr` stable while the FSM writes it to instruction memory.

Parameters:
- PKT_W, 8, packet width in bits
- NPKT, 4, packets per instruction word
- END_WORD, 32'hFFFF_FFFF, assembled value that marks end of program
- SYNC_STAGES, 2, flip-flop stages in the strobe synchronizer

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- data_in  in  PKT_W  packet byte from receiver; held stable by receiver from strobe rise until the next strobe
- strobe_in  in  1  packet-available strobe, asynchronous to clk, at least SYNC_STAGES+1 clk periods high
- activreg  in  1  capture enable from the FSM
- rstcont  in  1  synchronous clear of packet counter and `listo`, from the FSM
- instr  out  NPKT*PKT_W  last completed instruction word
- listo  out  1  word complete; held until `rstcont`
- opcode  out  1  end-of-program word received; sticky
- pkt_cnt  out  clog2(NPKT+1)  packets accepted into the current word
- overrun  out  1  sticky; a packet was dropped

Behaviour:
- Reset: `rst`=0 asynchronously clears all outputs and all internal registers (sync chain, edge flop, shift register, `instr`, `pkt_cnt`, `listo`, `opcode`, `overrun`) to 0.
- Strobe path: `strobe_in` passes through SYNC_STAGES flops, then a rising-edge detect produces a one-cycle `acc` pulse. With default parameters, `acc` is high in the 3rd rising clk edge after the strobe rises. `data_in` is sampled in the `acc` cycle.
- Accept condition: `acc` && `activreg` && !`rstcont` && !`listo` && !`opcode`.
- On accept:
  - shift register <= {shift[NPKT*PKT_W-PKT_W-1:0], data_in}; the first packet ends up in the MSBs (big-endian).
  - `pkt_cnt` increments.
- On the accept that makes `pkt_cnt` == NPKT, on the same edge:
  - `instr` <= the new shifted word.
  - `listo` <= 1.
  - `opcode` <= 1 if the new word == END_WORD.
  - Net result: `listo` and `instr` are valid 1 cycle after the final `acc`.
- `rstcont`=1 (synchronous, has priority over `acc`):
  - `pkt_cnt` <= 0 and `listo` <= 0.
  - `instr`, `opcode` and the shift register are unchanged, so `instr` stays valid during the FSM write state, where `rstcont` and `actwr` are high together.
- Dropped packet: `acc`=1 while any accept term fails → byte discarded and `overrun` <= 1. This covers `activreg`=0, `listo`=1, `rstcont`=1, and `opcode`=1 (packets after end-of-program).
- `opcode` and `overrun`: cleared only by `rst`.
- Simultaneous `rstcont` and `acc`: clear wins and the byte is dropped with `overrun`. The FSM never asserts `activreg` together with `rstcont`.
- `pkt_cnt` never exceeds NPKT; no wrap-around is possible because accepts are blocked while `listo`=1.
- Reset mid-word: partial word discarded; `instr` returns to 0.
- A strobe that is still high at reset release is not seen as an edge (edge flop resets to 0, sync chain to 0). It may produce one `acc` once the chain fills; a bench must not rely on this.
- Timing domain: the downstream FSM samples on falling edges. All outputs here are registered on rising edges, so they are stable for a half period before sampling.

Decomposition:
- Shared package holds:
  - PKT_W, NPKT and END_WORD constants
  - the packet-count width function
  - the instruction-word typedef (NPKT*PKT_W bits), shared with the instruction-memory writer
- One sub-module: `sync_edge` (SYNC_STAGES-flop synchronizer plus rising-edge pulse, async active-low reset). It is reusable for other receiver strobes.

Test Plan:
- `rst` low then high, no strobes → all outputs 0; `pkt_cnt`=0 for 20 cycles.
- `activreg`=1; strobes with 0x12, 0x34, 0x56, 0x78 → `pkt_cnt` steps 1..4. `instr`=0x12345678 and `listo`=1 one cycle after the 4th `acc`; `opcode`=0.
- After the previous case, pulse `rstcont` one cycle → `listo`=0, `pkt_cnt`=0, `instr` still 0x12345678. Next 4 packets 0xAA, 0xBB, 0xCC, 0xDD → `instr`=0xAABBCCDD.
- Four packets of 0xFF → `instr`=0xFFFFFFFF, `opcode`=1. A 5th strobe is dropped; `overrun`=1 and `instr` unchanged. `rstcont` does not clear `opcode`.
- Strobe while `activreg`=0, and a 5th strobe while `listo`=1 → `pkt_cnt` unchanged, `overrun`=1.
- Two packets accepted, then `rst` low mid-word → `instr`=0, `pkt_cnt`=0 immediately (asynchronously). After release, 4 packets 0x01, 0x02, 0x03, 0x04 → `instr`=0x01020304.
